// File: rtl/alu_pkg.sv
// Shared types and operation-decode helpers for the execute-stage ALU and
// the iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_signed(muldiv_op_t op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic b_signed(muldiv_op_t op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring trial-subtract divide step over the {hi, lo} register pair.
module muldiv_core_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // The partial remainder always stays below the divisor, so hi never needs
  // more than WIDTH bits; the WIDTH+1-bit trial value lives only in shifted.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, b};
    if (is_div) begin
      hi_nxt = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on magnitudes,
// sign fix-up at the end, start/ready handshake with flush.
//
// state | meaning
// IDLE  | ready for start; latches op/operands, resolves divide special cases
// CALC  | WIDTH iterations of shift-add or restoring subtract
// FIX   | sign correction and result select, result registered
// DONE  | result_valid pulse, back to IDLE
module muldiv_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             neg_res_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, fix_res;

  always_comb begin
    a_neg    = a_signed(op) & operand_a[WIDTH-1];
    b_neg    = b_signed(op) & operand_b[WIDTH-1];
    a_mag    = a_neg ? -operand_a : operand_a;
    b_mag    = b_neg ? -operand_b : operand_b;
    div_zero = op_is_div(op) && (operand_b == '0);
    div_ovf  = ((op == DIV) || (op == REM)) &&
               (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = op_is_rem(op) ? operand_a : '1;
    else          special_res = (op == DIV) ? operand_a : '0;
  end

  muldiv_core_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div(op_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_res_q ? -prod : prod;
    quo_s  = neg_res_q ? -lo_q : lo_q;
    rem_s  = neg_rem_q ? -hi_q : hi_q;
    case (op_q)
      MUL:                 fix_res = prod_s[WIDTH-1:0];
      MULH, MULHSU, MULHU: fix_res = prod_s[2*WIDTH-1:WIDTH];
      DIV, DIVU:           fix_res = quo_s;
      default:             fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        accept  = 1'b1;
        state_d = special ? DONE : CALC;
      end
      CALC: if (flush) state_d = IDLE;
            else if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready        = (state_q == IDLE);
    busy         = ~ready;
    result_valid = (state_q == DONE) && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else if (accept) begin
      op_q      <= op;
      hi_q      <= '0;
      lo_q      <= a_mag;
      b_q       <= b_mag;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      cnt_q     <= '0;
      if (special) begin
        result_q <= special_res;
        zero_q   <= (special_res == '0);
      end
    end else if (state_q == CALC) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (state_q == FIX && !flush) begin
      result_q <= fix_res;
      zero_q   <= (fix_res == '0);
    end
  end

  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a 64-bit arithmetic
// reference model.
module tb_muldiv_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  muldiv_op_t   op;
  logic [W-1:0] operand_a, operand_b, result;
  logic         ready, busy, result_valid, zero_flag;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .zero_flag    (zero_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(muldiv_op_t o, logic [W-1:0] a, logic [W-1:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [W-1:0] min_neg;
    min_neg = 32'h8000_0000;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    begin
        if (b == 0) return '1;
        if (a == min_neg && b == '1) return a;
        p = sa / sb; return p[31:0];
      end
      DIVU:   begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      REM:    begin
        if (b == 0) return a;
        if (a == min_neg && b == '1) return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_latency(muldiv_op_t o, logic [W-1:0] a, logic [W-1:0] b);
    logic signed_div;
    signed_div = (o == DIV) || (o == REM);
    if ((o inside {DIV, DIVU, REM, REMU}) && b == 0) return 1;
    if (signed_div && a == 32'h8000_0000 && b == '1) return 1;
    return W + 2;
  endfunction

  // Called at a negedge with the unit idle; returns one cycle after the pulse.
  task automatic do_op(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    logic [W-1:0] exp;
    int n;
    exp = model(o, a, b);
    check({tag, " ready"}, ready, 1);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    op = muldiv_op_t'($urandom_range(0, 7));
    n = 1;
    while (result_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, model_latency(o, a, b));
    check({tag, " result"}, result, exp);
    check({tag, " zero_flag"}, zero_flag, (exp == 0));
    @(negedge clk);
    check({tag, " pulse_end"}, result_valid, 0);
    check({tag, " ready_after"}, ready, 1);
  endtask

  initial begin
    logic [W-1:0] prev, a, b;
    muldiv_op_t o;
    int n, seen;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MUL; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset valid", result_valid, 0);
    check("reset result", result, 0);
    check("reset zero", zero_flag, 1);

    do_op(MUL,    32'd7,          32'hFFFF_FFFD, "mul_neg");
    do_op(MULH,   32'h8000_0000,  32'h8000_0000, "mulh_min");
    do_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu");
    do_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu");
    do_op(MUL,    32'd0,          32'd5,         "mul_zero");
    do_op(DIV,    32'hFFFF_FFF9,  32'd2,         "div_neg");
    do_op(REM,    32'hFFFF_FFF9,  32'd2,         "rem_neg");
    do_op(DIVU,   32'd100,        32'd7,         "divu");
    do_op(REMU,   32'd100,        32'd7,         "remu");
    do_op(DIVU,   32'd5,          32'd0,         "divu_by0");
    do_op(REM,    32'd5,          32'd0,         "rem_by0");
    do_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
    do_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");
    do_op(MUL,    32'd9,          32'd9,         "mul_prev");

    // Ignored start mid-flight, then flush: no result, result held.
    prev = result;
    op = MUL; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1; seen = 0;
    while (n < 5) begin @(negedge clk); n++; if (result_valid) seen++; end
    check("flush busy_c5", busy, 1);
    op = DIV; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    while (n < 10) begin @(negedge clk); n++; if (result_valid) seen++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush ready_c11", ready, 1);
    check("flush valid_c11", result_valid, 0);
    repeat (40) begin @(negedge clk); if (result_valid) seen++; end
    check("flush no_valid", seen, 0);
    check("flush result_held", result, prev);
    do_op(MUL, 32'd3, 32'd4, "mul_after_flush");

    // flush and start together while idle: start dropped.
    op = DIVU; operand_a = 32'd50; operand_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start ready", ready, 1);
    check("flush_start result", result, 32'd12);

    // Reset mid-divide.
    op = DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    while (n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst ready", ready, 1);
    check("rst result", result, 0);
    check("rst zero", zero_flag, 1);
    check("rst valid", result_valid, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (result_valid) seen++; end
    check("rst no_valid", seen, 0);
    do_op(DIV,  32'd1000,       32'd3,  "b2b_div");
    do_op(REMU, 32'd1000,       32'd3,  "b2b_remu");
    do_op(MULH, 32'hDEAD_BEEF,  32'h1234_5678, "b2b_mulh");

    for (int i = 0; i < 40; i++) begin
      o = muldiv_op_t'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 3);
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 255);
        default: ;
      endcase
      do_op(o, a, b, $sformatf("rand%0d_op%0d", i, o));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
